// File: rtl/imm_encoder_pkg.sv
// Shared RV32I format codes, opcode constants and the canonical NOP used by
// the immediate encoder, its range checker and the matching immediate generator.
package imm_encoder_pkg;
  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  function automatic logic fmt_legal(input logic [2:0] fmt);
    return fmt <= FMT_J;
  endfunction
endpackage

// File: rtl/imm_range_check.sv
// Combinational encodability check of an architectural immediate for one
// RV32I format. Formats without an immediate (R, illegal codes) report ok.
module imm_range_check
  import imm_encoder_pkg::*;
(
  input  logic [2:0]  i_fmt,
  input  logic [31:0] i_imm,
  output logic        o_ok
);
  logic signed [31:0] w_imm;
  assign w_imm = $signed(i_imm);

  always_comb begin
    o_ok = 1'b1;
    case (i_fmt)
      FMT_I, FMT_S: o_ok = (w_imm >= -32'sd2048) && (w_imm <= 32'sd2047);
      FMT_B:        o_ok = (w_imm >= -32'sd4096) && (w_imm <= 32'sd4094) && !i_imm[0];
      FMT_J:        o_ok = (w_imm >= -32'sd1048576) && (w_imm <= 32'sd1048574) && !i_imm[0];
      FMT_U:        o_ok = (i_imm[11:0] == 12'd0);
      default:      o_ok = 1'b1;
    endcase
  end
endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready RV32I instruction encoder (fields + immediate -> word).
// Define IMM_RANGE_CHECK_EN to reject immediates that the format cannot hold.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_WORD,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_err,
  output logic [2:0]       out_fmt,
  output logic [CNT_W-1:0] err_cnt
);
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic             w_adv1, w_adv2, w_ok, w_err;
  logic [31:0]      w_word;
  logic             r_vld_p1, r_ok_p1;
  logic [2:0]       r_fmt_p1, r_f3_p1;
  logic [6:0]       r_opc_p1, r_f7_p1;
  logic [4:0]       r_rd_p1, r_rs1_p1, r_rs2_p1;
  logic [31:0]      r_imm_p1;
  logic             r_vld_p2, r_err_p2;
  logic [31:0]      r_inst_p2;
  logic [2:0]       r_fmt_p2;
  logic [CNT_W-1:0] r_cnt;

  assign w_adv2   = !r_vld_p2 || out_ready;
  assign w_adv1   = !r_vld_p1 || w_adv2;
  assign in_ready = w_adv1;

`ifdef IMM_RANGE_CHECK_EN
  imm_range_check u_range (
    .i_fmt (in_fmt),
    .i_imm (in_imm),
    .o_ok  (w_ok)
  );
`else
  assign w_ok = 1'b1;
`endif

  // ---- stage 1: capture request fields and encodability verdict ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_vld_p1 <= 1'b0;
    else if (w_adv1) r_vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (w_adv1 && in_valid) begin
      r_fmt_p1 <= in_fmt;
      r_opc_p1 <= in_opcode;
      r_rd_p1  <= in_rd;
      r_rs1_p1 <= in_rs1;
      r_rs2_p1 <= in_rs2;
      r_f3_p1  <= in_funct3;
      r_f7_p1  <= in_funct7;
      r_imm_p1 <= in_imm;
      r_ok_p1  <= w_ok;
    end
  end

  always_comb begin
    w_word = NOP_INST;
    case (r_fmt_p1)
      FMT_R: w_word = {r_f7_p1, r_rs2_p1, r_rs1_p1, r_f3_p1, r_rd_p1, r_opc_p1};
      FMT_I: w_word = {r_imm_p1[11:0], r_rs1_p1, r_f3_p1, r_rd_p1, r_opc_p1};
      FMT_S: w_word = {r_imm_p1[11:5], r_rs2_p1, r_rs1_p1, r_f3_p1, r_imm_p1[4:0], r_opc_p1};
      FMT_B: w_word = {r_imm_p1[12], r_imm_p1[10:5], r_rs2_p1, r_rs1_p1, r_f3_p1,
                       r_imm_p1[4:1], r_imm_p1[11], r_opc_p1};
      FMT_U: w_word = {r_imm_p1[31:12], r_rd_p1, r_opc_p1};
      FMT_J: w_word = {r_imm_p1[20], r_imm_p1[10:1], r_imm_p1[11], r_imm_p1[19:12],
                       r_rd_p1, r_opc_p1};
      default: w_word = NOP_INST;
    endcase
    w_err = !fmt_legal(r_fmt_p1) || !r_ok_p1;
    if (w_err) w_word = NOP_INST;
  end

  // ---- stage 2: assembled word, held while the consumer stalls ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2  <= 1'b0;
      r_inst_p2 <= 32'd0;
      r_err_p2  <= 1'b0;
      r_fmt_p2  <= 3'd0;
    end else if (w_adv2) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_inst_p2 <= w_word;
        r_err_p2  <= w_err;
        r_fmt_p2  <= r_fmt_p1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (r_vld_p2 && out_ready && r_err_p2) r_cnt <= sat_inc(r_cnt);
  end

  assign out_valid = r_vld_p2;
  assign out_inst  = r_inst_p2;
  assign out_err   = r_err_p2;
  assign out_fmt   = r_fmt_p2;
  assign err_cnt   = r_cnt;
endmodule

// File: tb/tb_imm_encoder.sv
// Directed and randomized bench for imm_encoder against an arithmetic model
// of the RV32I immediate scatter; honours IMM_RANGE_CHECK_EN when defined.
module tb_imm_encoder;
  import imm_encoder_pkg::*;

  localparam int TB_CNT_W = 2;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } req_t;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
    logic [2:0]  fmt;
  } exp_t;

  logic clk, rst_n;
  logic in_valid, in_ready, out_valid, out_ready, out_err;
  logic [2:0] in_fmt, in_funct3, out_fmt;
  logic [6:0] in_opcode, in_funct7;
  logic [4:0] in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, out_inst;
  logic [TB_CNT_W-1:0] err_cnt;

  int total = 0;
  int bad = 0;

  imm_encoder #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_err(out_err), .out_fmt(out_fmt), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] bits(input logic [31:0] v, input int hi, input int lo);
    logic [31:0] mask;
    mask = (32'd1 << (hi - lo + 1)) - 32'd1;
    return (v >> lo) & mask;
  endfunction

  function automatic bit ref_err(input req_t r);
    int s;
    s = $signed(r.imm);
    if (r.fmt > 3'd5) return 1'b1;
`ifdef IMM_RANGE_CHECK_EN
    case (r.fmt)
      3'd1, 3'd2: return (s < -2048) || (s > 2047);
      3'd3:       return (s < -4096) || (s > 4094) || (r.imm[0] == 1'b1);
      3'd5:       return (s < -(1 << 20)) || (s > (1 << 20) - 2) || (r.imm[0] == 1'b1);
      3'd4:       return r.imm[11:0] != 12'd0;
      default:    return 1'b0;
    endcase
`else
    return s != s;
`endif
  endfunction

  function automatic logic [31:0] ref_inst(input req_t r);
    logic [31:0] op, rd, rs1, rs2, f3, f7, im;
    op = 32'(r.op); rd = 32'(r.rd); rs1 = 32'(r.rs1); rs2 = 32'(r.rs2);
    f3 = 32'(r.f3); f7 = 32'(r.f7); im = r.imm;
    if (ref_err(r)) return NOP_WORD;
    case (r.fmt)
      3'd0: return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      3'd1: return (bits(im, 11, 0) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      3'd2: return (bits(im, 11, 5) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                 | (bits(im, 4, 0) << 7) | op;
      3'd3: return (bits(im, 12, 12) << 31) | (bits(im, 10, 5) << 25) | (rs2 << 20)
                 | (rs1 << 15) | (f3 << 12) | (bits(im, 4, 1) << 8)
                 | (bits(im, 11, 11) << 7) | op;
      3'd4: return (im & 32'hFFFF_F000) | (rd << 7) | op;
      3'd5: return (bits(im, 20, 20) << 31) | (bits(im, 10, 1) << 21)
                 | (bits(im, 11, 11) << 20) | (bits(im, 19, 12) << 12) | (rd << 7) | op;
      default: return NOP_WORD;
    endcase
  endfunction

  function automatic exp_t ref_exp(input req_t r);
    exp_t e;
    e.inst = ref_inst(r);
    e.err  = ref_err(r);
    e.fmt  = r.fmt;
    return e;
  endfunction

  function automatic req_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm);
    req_t r;
    r.fmt = fmt; r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
    r.f3 = f3; r.f7 = f7; r.imm = imm;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int f;
    f = int'($urandom_range(0, 13));
    r.fmt = (f < 12) ? 3'(f % 6) : 3'(f - 6);
    r.op  = 7'($urandom); r.rd = 5'($urandom); r.rs1 = 5'($urandom);
    r.rs2 = 5'($urandom); r.f3 = 3'($urandom); r.f7 = 7'($urandom);
    case ($urandom_range(0, 3))
      0: r.imm = $urandom;
      1: r.imm = 32'(int'($urandom_range(0, 10000)) - 5000);
      2: r.imm = 32'((int'($urandom_range(0, 1 << 22)) - (1 << 21)) & ~1);
      default: r.imm = $urandom & 32'hFFFF_F000;
    endcase
    return r;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%b want=%b", tag, got, exp);
    end
  endtask

  task automatic drive(input req_t r);
    in_fmt = r.fmt; in_opcode = r.op; in_rd = r.rd; in_rs1 = r.rs1;
    in_rs2 = r.rs2; in_funct3 = r.f3; in_funct7 = r.f7; in_imm = r.imm;
  endtask

  // One request through an idle pipeline with out_ready=1, checking latency and result.
  task automatic send_dir(input string tag, input req_t r, input logic [31:0] exp_inst,
                          input logic exp_err);
    @(negedge clk);
    drive(r);
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1 chk1({tag, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk1({tag, "_early_valid"}, out_valid, 1'b0);
    @(posedge clk);
    #1 chk1({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_inst"}, out_inst, exp_inst);
    chk1({tag, "_err"}, out_err, exp_err);
    chk({tag, "_fmt"}, {29'd0, out_fmt}, {29'd0, r.fmt});
  endtask

  // ---------------- stimulus ----------------
  req_t rq, ra, rb, rc;
  exp_t q[$];
  exp_t e3[3];
  int   mcnt;
  int   idx;
  bit   acc, cons;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(mk(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0));
    #2;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk1("rst_out_err", out_err, 1'b0);
    chk("rst_out_fmt", {29'd0, out_fmt}, 32'd0);
    chk("rst_err_cnt", {30'd0, err_cnt}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    send_dir("i_addi", mk(FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5),
             32'h0050_0093, 1'b0);
    send_dir("s_sw", mk(FMT_S, OPC_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8),
             32'h0020_A423, 1'b0);
    send_dir("b_neg", mk(FMT_B, OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC),
             32'hFE00_0EE3, 1'b0);
    send_dir("j_jal", mk(FMT_J, OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048),
             32'h0010_00EF, 1'b0);
    send_dir("u_lui", mk(FMT_U, OPC_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000),
             32'h1234_52B7, 1'b0);
    send_dir("r_add", mk(FMT_R, OPC_OP, 5'd3, 5'd4, 5'd5, 3'd0, 7'b0100000, 32'hDEAD_BEEF),
             32'h4052_01B3, 1'b0);
`ifdef IMM_RANGE_CHECK_EN
    send_dir("i_2048", mk(FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048),
             32'h0000_0013, 1'b1);
    @(posedge clk);
    #1 chk("i_2048_cnt", {30'd0, err_cnt}, 32'd1);
`else
    send_dir("i_2048", mk(FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048),
             32'h8000_0093, 1'b0);
    @(posedge clk);
    #1 chk("i_2048_cnt", {30'd0, err_cnt}, 32'd0);
`endif

    // Immediate range boundaries, expected values from the model.
    begin
      req_t tbl[12];
      tbl[0]  = mk(FMT_I, OPC_OP_IMM, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd2047);
      tbl[1]  = mk(FMT_I, OPC_OP_IMM, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800);
      tbl[2]  = mk(FMT_S, OPC_STORE, 5'd0, 5'd3, 5'd4, 3'd2, 7'd0, 32'hFFFF_F7FF);
      tbl[3]  = mk(FMT_B, OPC_BRANCH, 5'd0, 5'd6, 5'd7, 3'd1, 7'd0, 32'd4094);
      tbl[4]  = mk(FMT_B, OPC_BRANCH, 5'd0, 5'd6, 5'd7, 3'd1, 7'd0, 32'hFFFF_F000);
      tbl[5]  = mk(FMT_B, OPC_BRANCH, 5'd0, 5'd6, 5'd7, 3'd1, 7'd0, 32'd4096);
      tbl[6]  = mk(FMT_B, OPC_BRANCH, 5'd0, 5'd6, 5'd7, 3'd1, 7'd0, 32'd6 + 32'd1);
      tbl[7]  = mk(FMT_J, OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048574);
      tbl[8]  = mk(FMT_J, OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF0_0000);
      tbl[9]  = mk(FMT_J, OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048576);
      tbl[10] = mk(FMT_U, OPC_LUI, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E001);
      tbl[11] = mk(3'd6, OPC_OP, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
      for (int i = 0; i < 12; i++)
        send_dir($sformatf("bnd%0d", i), tbl[i], ref_inst(tbl[i]), ref_err(tbl[i]));
    end

    send_dir("fmt7", mk(3'd7, OPC_OP_IMM, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd1),
             32'h0000_0013, 1'b1);

    // Saturation: five illegal-format results must pin the 2-bit counter at 3.
    @(negedge clk);
    drive(mk(3'd7, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0));
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("cnt_sat", {30'd0, err_cnt}, 32'd3);
    chk1("cnt_sat_idle", out_valid, 1'b0);

    // Back-pressure: three back-to-back requests against a stalled consumer.
    ra = mk(FMT_I, OPC_OP_IMM, 5'd10, 5'd11, 5'd0, 3'd4, 7'd0, 32'd100);
    rb = mk(FMT_S, OPC_STORE, 5'd0, 5'd12, 5'd13, 3'd0, 7'd0, 32'hFFFF_FFF0);
    rc = mk(FMT_R, OPC_OP, 5'd14, 5'd15, 5'd16, 3'd7, 7'd0, 32'd0);
    e3[0] = ref_exp(ra); e3[1] = ref_exp(rb); e3[2] = ref_exp(rc);
    @(negedge clk);
    out_ready = 1'b0; drive(ra); in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); drive(rb);
    @(posedge clk);
    @(negedge clk); drive(rc);
    #1 chk1("stall_in_ready", in_ready, 1'b0);
    chk("stall_inst0", out_inst, e3[0].inst);
    @(posedge clk);
    @(negedge clk);
    #1 chk1("stall_in_ready2", in_ready, 1'b0);
    chk("stall_hold", out_inst, e3[0].inst);
    chk1("stall_hold_vld", out_valid, 1'b1);
    out_ready = 1'b1;
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (out_valid && idx < 3) begin
        chk($sformatf("stall_out%0d", idx), out_inst, e3[idx].inst);
        idx++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      #1 if (acc) in_valid = 1'b0;
      @(negedge clk);
    end
    chk("stall_count", 32'(idx), 32'd3);

    // Asynchronous reset while a result is waiting.
    out_ready = 1'b0;
    drive(ra); in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1 chk1("pre_rst_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1 chk1("arst_valid", out_valid, 1'b0);
    chk("arst_cnt", {30'd0, err_cnt}, 32'd0);
    chk("arst_inst", out_inst, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with random back-pressure against a scoreboard.
    mcnt = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rq = rand_req();
      drive(rq);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid) begin
        total++;
        assert (q.size() > 0) else begin
          bad++;
          $error("FAIL rnd_spurious got=1 want=0");
        end
        if (q.size() > 0) begin
          chk("rnd_inst", out_inst, q[0].inst);
          chk1("rnd_err", out_err, q[0].err);
          chk("rnd_fmt", {29'd0, out_fmt}, {29'd0, q[0].fmt});
        end
      end
      chk("rnd_cnt", {30'd0, err_cnt}, 32'(mcnt));
      acc  = in_valid && in_ready;
      cons = out_valid && out_ready;
      @(posedge clk);
      if (cons && q.size() > 0) begin
        if (q[0].err && mcnt < 3) mcnt++;
        void'(q.pop_front());
      end
      if (acc) q.push_back(ref_exp(rq));
    end

    // Drain with a bounded cycle budget.
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (out_valid && q.size() > 0) begin
        chk("drain_inst", out_inst, q[0].inst);
        void'(q.pop_front());
      end
      @(negedge clk);
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
    chk1("drain_idle", out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
